// File: rtl/sensor_conditioner.sv
// Block-averages moisture/light ADC codes into hysteretic dryness flags and a debounced light class.
// One cycle from the window-completing strobe to registered outputs and out_valid; no backpressure.
module sensor_conditioner #(
   parameter int DATA_W   = 8,
   parameter int AVG_LOG2 = 2,
   parameter int CONFIRM  = 3,
   parameter int HYST     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] m_adc,
   input  logic [DATA_W-1:0] l_adc,
   input  logic [DATA_W-1:0] m_level_1,
   input  logic [DATA_W-1:0] m_level_2,
   input  logic [DATA_W-1:0] l_dark,
   input  logic [DATA_W-1:0] l_bright,
   output logic [DATA_W-1:0] m_avg,
   output logic [DATA_W-1:0] l_avg,
   output logic              m_dry,
   output logic              m_very_dry,
   output logic [1:0]        l_class,
   output logic              out_valid
);

   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = $clog2(CONFIRM + 1);

   typedef enum logic [1:0] {
      NIGHT = 2'b00,
      DAWN  = 2'b01,
      DAY   = 2'b10,
      DUSK  = 2'b11
   } light_t;

   logic [AVG_LOG2-1:0] sample_cnt;
   logic [ACC_W-1:0]    m_acc;
   logic [ACC_W-1:0]    l_acc;
   logic [ACC_W-1:0]    m_sum;
   logic [ACC_W-1:0]    l_sum;
   logic [ACC_W-1:0]    m_shift;
   logic [ACC_W-1:0]    l_shift;
   logic [DATA_W-1:0]   m_new;
   logic [DATA_W-1:0]   l_new;
   logic                window_done;

   light_t              light_state;
   light_t              last_target;
   light_t              target;
   logic                target_hit;
   logic [CNT_W-1:0]    confirm_cnt;
   logic [CNT_W-1:0]    confirm_nxt;

   // The completing sample is folded in combinationally so its window lands without an extra cycle.
   assign m_sum       = m_acc + ACC_W'(m_adc);
   assign l_sum       = l_acc + ACC_W'(l_adc);
   assign m_shift     = m_sum >> AVG_LOG2;
   assign l_shift     = l_sum >> AVG_LOG2;
   assign m_new       = m_shift[DATA_W-1:0];
   assign l_new       = l_shift[DATA_W-1:0];
   assign window_done = sample_valid && (sample_cnt == {AVG_LOG2{1'b1}});
   assign l_class     = light_state;

   function automatic logic [DATA_W-1:0] clear_level(input logic [DATA_W-1:0] level);
      logic [DATA_W:0] sum;
      sum = {1'b0, level} + (DATA_W+1)'(HYST);
      return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
   endfunction

   function automatic logic hyst_flag(input logic              prev,
                                      input logic [DATA_W-1:0] avg,
                                      input logic [DATA_W-1:0] level);
      logic flag;
      flag = prev;
      if (avg < level) begin
         flag = 1'b1;
      end else if (avg >= clear_level(level)) begin
         flag = 1'b0;
      end
      return flag;
   endfunction

   // Exit target for the new light average; brighter target wins when both conditions hold.
   always_comb begin
      target_hit = 1'b0;
      target     = light_state;
      unique case (light_state)
         NIGHT: begin
            if (l_new >= l_dark) begin
               target_hit = 1'b1;
               target     = DAWN;
            end
         end
         DAY: begin
            if (l_new < l_bright) begin
               target_hit = 1'b1;
               target     = DUSK;
            end
         end
         DAWN, DUSK: begin
            if (l_new >= l_bright) begin
               target_hit = 1'b1;
               target     = DAY;
            end else if (l_new < l_dark) begin
               target_hit = 1'b1;
               target     = NIGHT;
            end
         end
         default: begin
            target_hit = 1'b0;
            target     = light_state;
         end
      endcase
   end

   // A switch between DAWN/DUSK exit directions restarts the shared count at this update.
   always_comb begin
      confirm_nxt = '0;
      if (target_hit) begin
         if ((confirm_cnt != '0) && (target != last_target)) begin
            confirm_nxt = CNT_W'(1);
         end else begin
            confirm_nxt = confirm_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sample_cnt  <= '0;
         m_acc       <= '0;
         l_acc       <= '0;
         m_avg       <= '0;
         l_avg       <= '0;
         m_dry       <= 1'b0;
         m_very_dry  <= 1'b0;
         out_valid   <= 1'b0;
         light_state <= NIGHT;
         last_target <= NIGHT;
         confirm_cnt <= '0;
      end else begin
         out_valid <= 1'b0;
         if (sample_valid) begin
            sample_cnt <= sample_cnt + AVG_LOG2'(1);
            if (window_done) begin
               m_acc      <= '0;
               l_acc      <= '0;
               m_avg      <= m_new;
               l_avg      <= l_new;
               m_dry      <= hyst_flag(m_dry, m_new, m_level_1);
               m_very_dry <= hyst_flag(m_very_dry, m_new, m_level_2);
               out_valid  <= 1'b1;
               if (target_hit) begin
                  last_target <= target;
               end
               if (target_hit && (confirm_nxt == CNT_W'(CONFIRM))) begin
                  light_state <= target;
                  confirm_cnt <= '0;
               end else begin
                  confirm_cnt <= confirm_nxt;
               end
            end else begin
               m_acc <= m_sum;
               l_acc <= l_sum;
            end
         end
      end
   end

endmodule
